// File: rtl/ucore_pkg.sv
// Shared definitions for the ucore stream FIFOs (output side now, input side later).
package ucore_pkg;

  // Default port geometry emitted by the core generator.
  localparam int unsigned UCORE_WIDTH = 32;
  localparam int unsigned UCORE_DEPTH = 4;

  // Occupancy classes decoded from a FIFO fill level.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ucore_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module ucore_fifo_mem import ucore_pkg::*; #(
  parameter int unsigned WIDTH = UCORE_WIDTH,
  parameter int unsigned DEPTH = UCORE_DEPTH,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ucore_out_fifo.sv
// Output-port FIFO for a ucore: queues strobed core writes and presents them
// as a first-word fall-through valid/ready stream, counting dropped writes.
module ucore_out_fifo import ucore_pkg::*; #(
  parameter int unsigned WIDTH = UCORE_WIDTH,
  parameter int unsigned DEPTH = UCORE_DEPTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   core_wr_en,
  input  logic [WIDTH-1:0]       core_wr_data,
  output logic                   core_full,
  input  logic                   flush,
  output logic                   m_valid,
  output logic [WIDTH-1:0]       m_data,
  input  logic                   m_ready,
  output logic [clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]       overflow_cnt
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          ovf_evt;
  occ_e          occ;

  // Occupancy class from the registered level only, so flags have no input paths.
  always_comb begin
    occ = OCC_PARTIAL;
    if (level == '0) begin
      occ = OCC_EMPTY;
    end else if (level == FULL_LEVEL) begin
      occ = OCC_FULL;
    end
  end

  assign core_full = (occ == OCC_FULL);
  assign m_valid   = (occ != OCC_EMPTY);

  assign push    = core_wr_en & ~core_full;
  assign pop     = m_valid & m_ready;
  assign ovf_evt = core_wr_en & core_full;

  ucore_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (core_wr_data),
    .raddr (rd_ptr),
    .rdata (m_data)
  );

  // Pointers and level; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Saturating count of writes dropped because the FIFO was full; only reset clears it.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_cnt <= '0;
    end else if (ovf_evt && (overflow_cnt != '1)) begin
      overflow_cnt <= overflow_cnt + CNT_W'(1);
    end
  end

endmodule
